// File: rtl/pci_master.sv
// rtl/pci_master.sv - PCI bus master for single-word and burst memory reads and writes
// Drives one bus transaction of 1..4 words per start request; a target that never claims it is master-aborted.
module pci_master #(
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        REQ,
    input  logic        GNT,
    input  logic        frame_in,
    input  logic        irdy_in,
    input  logic        TRDY,
    input  logic        DEVSEL,
    output logic        frame_out,
    output logic        irdy_out,
    output logic        ctl_oe,
    output logic [31:0] ad_out,
    input  logic [31:0] ad_in,
    output logic        ad_oe,
    output logic [3:0]  cbe_out,
    input  logic        start,
    input  logic        cmd_write,
    input  logic [31:0] addr,
    input  logic [1:0]  num_words,
    input  logic        wr_we,
    input  logic [1:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        abort
);

    typedef enum logic [2:0] {IDLE, REQ_BUS, ADDR, DATA, ABORT, RELEASE} state_t;

    localparam logic [7:0] TO_LIMIT = 8'(DEVSEL_TIMEOUT);

    state_t      state;
    logic [31:0] wbuf [4];
    logic [31:0] rbuf [4];
    logic        cmd_q;
    logic [31:0] addr_q;
    logic [1:0]  nw_q;
    logic [1:0]  idx;
    logic [1:0]  idx_nx;
    logic [7:0]  to_cnt;
    logic        devsel_seen;

    assign idx_nx  = idx + 2'd1;
    assign busy    = (state != IDLE);
    assign rd_data = rbuf[rd_idx];

    // Outputs are registered: each transition loads the values the next state presents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            REQ         <= 1'b1;
            frame_out   <= 1'b1;
            irdy_out    <= 1'b1;
            ctl_oe      <= 1'b0;
            ad_oe       <= 1'b0;
            ad_out      <= '0;
            cbe_out     <= '0;
            done        <= 1'b0;
            abort       <= 1'b0;
            cmd_q       <= 1'b0;
            addr_q      <= '0;
            nw_q        <= '0;
            idx         <= '0;
            to_cnt      <= '0;
            devsel_seen <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wbuf[i] <= '0;
                rbuf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (wr_we) wbuf[wr_idx] <= wr_data;
                    if (start) begin
                        cmd_q  <= cmd_write;
                        addr_q <= addr;
                        nw_q   <= num_words;
                        REQ    <= 1'b0;
                        state  <= REQ_BUS;
                    end
                end
                REQ_BUS: begin
                    // Wait for grant and an idle bus before claiming it.
                    if (!GNT && frame_in && irdy_in) begin
                        state       <= ADDR;
                        REQ         <= 1'b1;
                        ctl_oe      <= 1'b1;
                        frame_out   <= 1'b0;
                        irdy_out    <= 1'b1;
                        ad_oe       <= 1'b1;
                        ad_out      <= addr_q;
                        cbe_out     <= cmd_q ? 4'b0111 : 4'b0110;
                        idx         <= '0;
                        to_cnt      <= '0;
                        devsel_seen <= 1'b0;
                    end
                end
                ADDR: begin
                    state     <= DATA;
                    irdy_out  <= 1'b0;
                    cbe_out   <= 4'b0000;
                    frame_out <= (nw_q == 2'd0);
                    ad_oe     <= cmd_q;
                    ad_out    <= cmd_q ? wbuf[0] : '0;
                end
                DATA: begin
                    if (!DEVSEL) devsel_seen <= 1'b1;
                    if (DEVSEL && !devsel_seen) begin
                        to_cnt <= to_cnt + 8'd1;
                        if (to_cnt + 8'd1 >= TO_LIMIT) begin
                            state     <= ABORT;
                            frame_out <= 1'b1;
                            ad_oe     <= 1'b0;
                            ad_out    <= '0;
                        end
                    end else if (!TRDY && !DEVSEL) begin
                        if (!cmd_q) rbuf[idx] <= ad_in;
                        idx <= idx_nx;
                        if (idx == nw_q) begin
                            state     <= RELEASE;
                            frame_out <= 1'b1;
                            irdy_out  <= 1'b1;
                            ad_oe     <= 1'b0;
                            ad_out    <= '0;
                            done      <= 1'b1;
                        end else begin
                            frame_out <= (idx_nx == nw_q);
                            ad_out    <= cmd_q ? wbuf[idx_nx] : '0;
                        end
                    end
                end
                ABORT: begin
                    state    <= RELEASE;
                    irdy_out <= 1'b1;
                    done     <= 1'b1;
                    abort    <= 1'b1;
                end
                RELEASE: begin
                    state  <= IDLE;
                    ctl_oe <= 1'b0;
                    done   <= 1'b0;
                    abort  <= 1'b0;
                    REQ    <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pci_master.sv
// tb/tb_pci_master.sv - directed self-checking bench for pci_master
module tb_pci_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        REQ, GNT, frame_in, irdy_in, TRDY, DEVSEL;
    logic        frame_out, irdy_out, ctl_oe, ad_oe;
    logic [31:0] ad_out, ad_in, addr, wr_data, rd_data;
    logic [3:0]  cbe_out;
    logic        start, cmd_write, wr_we, busy, done, abort;
    logic [1:0]  num_words, wr_idx, rd_idx;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_data;
    logic [31:0] wq [$];
    logic [31:0] rq [$];
    logic [31:0] wexp [4];

    always #5 clk = ~clk;

    pci_master #(.DEVSEL_TIMEOUT(5)) dut (
        .clk(clk), .rst_n(rst_n), .REQ(REQ), .GNT(GNT),
        .frame_in(frame_in), .irdy_in(irdy_in), .TRDY(TRDY), .DEVSEL(DEVSEL),
        .frame_out(frame_out), .irdy_out(irdy_out), .ctl_oe(ctl_oe),
        .ad_out(ad_out), .ad_in(ad_in), .ad_oe(ad_oe), .cbe_out(cbe_out),
        .start(start), .cmd_write(cmd_write), .addr(addr), .num_words(num_words),
        .wr_we(wr_we), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .busy(busy), .done(done), .abort(abort)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0; GNT = 1'b1; frame_in = 1'b1; irdy_in = 1'b1;
        TRDY = 1'b1; DEVSEL = 1'b1; ad_in = '0; start = 1'b0; cmd_write = 1'b0;
        addr = '0; num_words = '0; wr_we = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        repeat (2) cyc();
        chk("rst_req", REQ, 1);       chk("rst_frame", frame_out, 1);
        chk("rst_irdy", irdy_out, 1); chk("rst_ctl_oe", ctl_oe, 0);
        chk("rst_ad_oe", ad_oe, 0);   chk("rst_ad", ad_out, 0);
        chk("rst_cbe", cbe_out, 0);   chk("rst_done", done, 0);
        chk("rst_abort", abort, 0);   chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc();

        // 4-word write, grant two cycles after request
        for (int i = 0; i < 4; i++) begin
            wr_we = 1'b1; wr_idx = 2'(i); wr_data = $urandom;
            wexp[i] = wr_data; wq.push_back(wr_data);
            cyc();
        end
        wr_we = 1'b0;
        start = 1'b1; cmd_write = 1'b1; addr = 32'h1000_0040; num_words = 2'd3;
        cyc();
        start = 1'b0;
        chk("wr_req_low", REQ, 0); chk("wr_busy", busy, 1);
        cyc();
        chk("wr_wait_gnt", ctl_oe, 0);
        GNT = 1'b0;
        cyc();
        chk("wr_addr_ctl_oe", ctl_oe, 1); chk("wr_addr_frame", frame_out, 0);
        chk("wr_addr_irdy", irdy_out, 1); chk("wr_addr_ad_oe", ad_oe, 1);
        chk("wr_addr_ad", ad_out, 32'h1000_0040); chk("wr_addr_cbe", cbe_out, 4'b0111);
        chk("wr_addr_req", REQ, 1);
        TRDY = 1'b0; DEVSEL = 1'b0; GNT = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("wr_data_ad", ad_out, wq.pop_front());
            chk("wr_data_frame", frame_out, (i == 3));
            chk("wr_data_irdy", irdy_out, 0);
            chk("wr_data_ad_oe", ad_oe, 1);
            chk("wr_data_cbe", cbe_out, 0);
        end
        cyc();
        chk("wr_rel_done", done, 1); chk("wr_rel_abort", abort, 0);
        chk("wr_rel_frame", frame_out, 1); chk("wr_rel_irdy", irdy_out, 1);
        chk("wr_rel_ctl_oe", ctl_oe, 1);
        cyc();
        chk("wr_idle_done", done, 0); chk("wr_idle_busy", busy, 0); chk("wr_idle_ctl_oe", ctl_oe, 0);

        // single-word read with two wait states
        TRDY = 1'b1; DEVSEL = 1'b0; GNT = 1'b0; ad_in = 32'hCAFE_0001;
        rq.push_back(32'hCAFE_0001);
        start = 1'b1; cmd_write = 1'b0; addr = 32'h2000_0000; num_words = 2'd0;
        cyc();
        start = 1'b0;
        cyc();
        chk("rd_addr_cbe", cbe_out, 4'b0110); chk("rd_addr_ad", ad_out, 32'h2000_0000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rd_data_ad_oe", ad_oe, 0); chk("rd_data_frame", frame_out, 1);
            chk("rd_data_irdy", irdy_out, 0); chk("rd_data_done", done, 0);
        end
        TRDY = 1'b0;
        cyc();
        chk("rd_rel_done", done, 1); chk("rd_rel_abort", abort, 0);
        rd_idx = 2'd0;
        #1;
        chk("rd_rbuf0", rd_data, rq.pop_front());
        cyc();

        // master abort: DEVSEL never asserted
        DEVSEL = 1'b1; TRDY = 1'b0;
        start = 1'b1; cmd_write = 1'b0; addr = 32'h3000_0000; num_words = 2'd1;
        cyc();
        start = 1'b0;
        cyc();
        chk("ab_addr_ctl_oe", ctl_oe, 1);
        n_data = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (irdy_out === 1'b0 && frame_out === 1'b0) n_data++;
            else break;
        end
        chk("ab_data_cycles", 32'(n_data), 5);
        chk("ab_frame", frame_out, 1); chk("ab_irdy", irdy_out, 0);
        chk("ab_ctl_oe", ctl_oe, 1); chk("ab_ad_oe", ad_oe, 0); chk("ab_done", done, 0);
        cyc();
        chk("ab_rel_done", done, 1); chk("ab_rel_abort", abort, 1); chk("ab_rel_irdy", irdy_out, 1);
        cyc();
        chk("ab_idle_abort", abort, 0); chk("ab_idle_busy", busy, 0);
        chk("ab_rbuf0_kept", rd_data, 32'hCAFE_0001);

        // bus busy holds REQ_BUS; start and wr_we while busy are ignored
        GNT = 1'b0; frame_in = 1'b0; DEVSEL = 1'b0; TRDY = 1'b0;
        start = 1'b1; cmd_write = 1'b1; addr = 32'h4000_0000; num_words = 2'd0;
        wq.push_back(wexp[0]);
        cyc();
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; cmd_write = 1'b0; addr = 32'h5555_0000; num_words = 2'd3;
            wr_we = 1'b1; wr_idx = 2'd0; wr_data = 32'hDEAD_BEEF;
            cyc();
            chk("arb_req_low", REQ, 0); chk("arb_no_addr", ctl_oe, 0);
        end
        start = 1'b0; wr_we = 1'b0; frame_in = 1'b1;
        cyc();
        chk("arb_addr_ad", ad_out, 32'h4000_0000); chk("arb_addr_cbe", cbe_out, 4'b0111);
        cyc();
        chk("arb_data_frame", frame_out, 1); chk("arb_data_ad", ad_out, wq.pop_front());
        cyc();
        chk("arb_rel_done", done, 1);
        cyc();

        // reset in the middle of a 4-word write
        TRDY = 1'b1; DEVSEL = 1'b0; GNT = 1'b0;
        start = 1'b1; cmd_write = 1'b1; addr = 32'h6000_0000; num_words = 2'd3;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("mr_data_ad_oe", ad_oe, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ctl_oe", ctl_oe, 0); chk("mr_ad_oe", ad_oe, 0);
        chk("mr_req", REQ, 1); chk("mr_busy", busy, 0); chk("mr_frame", frame_out, 1);
        cyc();
        chk("mr_done", done, 0); chk("mr_rbuf_clr", rd_data, 0);
        rst_n = 1'b1;
        cyc();
        chk("mr_post_done", done, 0); chk("mr_post_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
